// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// Results go to the HI/LO registers over the muldiv source path.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   operation request, sampled every cycle
//   funct  in   operation select (selector::muldiv_funct_t)
//   a      in   [31:0] multiplicand / dividend
//   b      in   [31:0] multiplier / divisor
//   flush  in   aborts any operation; no done, hi/lo untouched
//   busy   out  operation in flight (drives the hazard stall)
//   done   out  one-cycle pulse, hi/lo valid
//   hi     out  [31:0] upper product or remainder
//   lo     out  [31:0] lower product or quotient

package selector;
  typedef enum logic [2:0] {
    MULDIV_NCARE = 3'd0,
    MULDIV_MULT  = 3'd1,
    MULDIV_MULTU = 3'd2,
    MULDIV_DIV   = 3'd3,
    MULDIV_DIVU  = 3'd4
  } muldiv_funct_t;
endpackage

// state | meaning
// IDLE  | waiting for start; the done cycle is spent here
// MUL   | multiply in flight, mcnt counts down to the result edge
// DIV   | one restoring-divide iteration per cycle, dcnt 31..0
// FIX   | quotient/remainder sign correction, result registered
module muldiv_unit #(
  parameter int MUL_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  selector::muldiv_funct_t funct,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             hi,
  output logic [31:0]             lo
);
  import selector::*;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [1:0] MCNT_INIT = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;

  state_t      state, state_d;
  logic        busy_d, done_d, mul_fin, div_fin;
  logic        accept, is_mul;
  logic [1:0]  mcnt;
  logic [4:0]  dcnt;
  logic [31:0] a_q, b_q;
  logic        msigned_q;
  logic [63:0] rq;
  logic [31:0] dsr;
  logic        negq, negr;

  assign accept = start && !flush && (state == IDLE) && (funct != MULDIV_NCARE);
  assign is_mul = (funct == MULDIV_MULT) || (funct == MULDIV_MULTU);

  // With MUL_LATENCY=1 the product is registered at the acceptance edge,
  // so in IDLE the multiplier looks straight at the input operands.
  logic [31:0] ma, mb;
  logic        msg;
  logic [63:0] prod;
  assign ma   = (state == IDLE) ? a : a_q;
  assign mb   = (state == IDLE) ? b : b_q;
  assign msg  = (state == IDLE) ? (funct == MULDIV_MULT) : msigned_q;
  // Sign-extending to 64 bits makes the low 64 bits of the product correct
  // for both signed and unsigned operands.
  assign prod = {{32{msg & ma[31]}}, ma} * {{32{msg & mb[31]}}, mb};

  // Divider operand magnitudes; |0x80000000| stays 0x80000000 in 32 bits.
  logic        sdiv;
  logic [31:0] abs_a, abs_b;
  assign sdiv  = (funct == MULDIV_DIV);
  assign abs_a = (sdiv && a[31]) ? 32'd0 - a : a;
  assign abs_b = (sdiv && b[31]) ? 32'd0 - b : b;

  // Shifted partial remainder needs 33 bits when the divisor exceeds 2^31.
  logic [33:0] diff;
  logic [63:0] rq_step;
  assign diff    = {1'b0, rq[63:31]} - {2'b00, dsr};
  assign rq_step = diff[33] ? {rq[62:0], 1'b0} : {diff[31:0], rq[30:0], 1'b1};

  logic [31:0] fix_q, fix_r;
  assign fix_q = negq ? 32'd0 - rq[31:0]  : rq[31:0];
  assign fix_r = negr ? 32'd0 - rq[63:32] : rq[63:32];

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    mul_fin = 1'b0;
    div_fin = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_mul) begin
            state_d = DIV;
          end else if (MUL_LATENCY == 1) begin
            done_d  = 1'b1;
            mul_fin = 1'b1;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (mcnt == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          mul_fin = 1'b1;
        end
      end
      DIV: begin
        if (dcnt == 5'd0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        div_fin = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      mul_fin = 1'b0;
      div_fin = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      if (mul_fin) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end
      if (div_fin) begin
        hi <= fix_r;
        lo <= fix_q;
      end
    end
  end

  // Datapath registers need no reset: they are loaded at every acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q       <= a;
      b_q       <= b;
      msigned_q <= (funct == MULDIV_MULT);
      mcnt      <= MCNT_INIT;
      dcnt      <= 5'd31;
      rq        <= {32'd0, abs_a};
      dsr       <= abs_b;
      negq      <= sdiv && (a[31] != b[31]);
      negr      <= sdiv && a[31];
    end else begin
      if (state == MUL) mcnt <= mcnt - 2'd1;
      if (state == DIV) begin
        rq   <= rq_step;
        dcnt <= dcnt - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: two instances (MUL_LATENCY 3 and 1)
// share stimulus; results are compared with a plain-arithmetic model.
module tb_muldiv_unit;
  import selector::*;

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  muldiv_funct_t funct;
  logic [31:0]   a, b;
  logic          busy3, done3, busy1, done1;
  logic [31:0]   hi3, lo3, hi1, lo1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy3), .done(done3), .hi(hi3), .lo(lo3));

  muldiv_unit #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo}.
  function automatic logic [63:0] model(muldiv_funct_t f, logic [31:0] x, logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [31:0] q, r;
    q = '0;
    r = '0;
    case (f)
      MULDIV_MULT:  return 64'(sx * sy);
      MULDIV_MULTU: return {32'd0, x} * {32'd0, y};
      MULDIV_DIV: begin
        if (y == 0) begin
          q = x[31] ? 32'd1 : 32'hFFFF_FFFF;
          r = x;
        end else begin
          q = 32'(sx / sy);
          r = 32'(sx % sy);
        end
      end
      MULDIV_DIVU: begin
        if (y == 0) begin
          q = 32'hFFFF_FFFF;
          r = x;
        end else begin
          q = x / y;
          r = x % y;
        end
      end
      default: return 64'd0;
    endcase
    return {r, q};
  endfunction

  function automatic bit fmul(muldiv_funct_t f);
    return (f == MULDIV_MULT) || (f == MULDIV_MULTU);
  endfunction

  // Caller is at a negedge; this cycle becomes cycle 0. Optional injection of
  // a second start at cycle inj_c (expected to be dropped while busy).
  task automatic run_op(input string tag, input muldiv_funct_t f, input logic [31:0] x,
                        input logic [31:0] y, input int inj_c, output logic [63:0] exp);
    int dc3 = -1, dc1 = -1, nd3 = 0, nd1 = 0;
    bit bok3 = 1, bok1 = 1;
    logic [63:0] r3 = '0, r1 = '0;
    int lat3 = fmul(f) ? 3 : 34;
    int lat1 = fmul(f) ? 1 : 34;
    exp   = model(f, x, y);
    start = 1'b1;
    funct = f;
    a     = x;
    b     = y;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done3) begin nd3++; dc3 = c; r3 = {hi3, lo3}; end
      if (done1) begin nd1++; dc1 = c; r1 = {hi1, lo1}; end
      if (busy3 !== (c < lat3)) bok3 = 0;
      if (busy1 !== (c < lat1)) bok1 = 0;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      funct = MULDIV_MULTU;
      if (c == inj_c) start = 1'b1;
    end
    chk({tag, "_cyc3"}, 64'(dc3), 64'(lat3));
    chk({tag, "_cyc1"}, 64'(dc1), 64'(lat1));
    chk({tag, "_n3"}, 64'(nd3), 64'd1);
    chk({tag, "_n1"}, 64'(nd1), 64'd1);
    chk({tag, "_res3"}, r3, exp);
    chk({tag, "_res1"}, r1, exp);
    chk({tag, "_busy3"}, 64'(bok3), 64'd1);
    chk({tag, "_busy1"}, 64'(bok1), 64'd1);
    chk({tag, "_hold3"}, {hi3, lo3}, exp);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  logic [63:0]   e, prev;
  muldiv_funct_t fr;
  int            nd, dq3[$], dq1[$];
  logic [63:0]   vq3[$], vq1[$];

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = MULDIV_NCARE; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset3", {busy3, done3, hi3, lo3}, 66'd0);
    chk("reset1", {busy1, done1, hi1, lo1}, 66'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult", MULDIV_MULT, 32'hFFFF_FFFD, 32'd5, 0, e);
    chk("mult_const", {hi3, lo3}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("multu", MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, e);
    chk("multu_const", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);
    run_op("div", MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 0, e);
    chk("div_const", {hi3, lo3}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, e);
    chk("ovf_const", {hi3, lo3}, 64'h0000_0000_8000_0000);
    run_op("divu0", MULDIV_DIVU, 32'd5, 32'd0, 0, e);
    chk("divu0_const", {hi3, lo3}, 64'h0000_0005_FFFF_FFFF);
    run_op("div0n", MULDIV_DIV, 32'hFFFF_FFFB, 32'd0, 0, e);
    chk("div0n_const", {hi3, lo3}, 64'hFFFF_FFFB_0000_0001);
    run_op("div0p", MULDIV_DIV, 32'd9, 32'd0, 0, e);

    // start while busy is dropped
    run_op("drop", MULDIV_DIV, 32'd100, 32'd7, 5, e);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: fr = MULDIV_MULT;
        1: fr = MULDIV_MULTU;
        2: fr = MULDIV_DIV;
        default: fr = MULDIV_DIVU;
      endcase
      run_op($sformatf("rnd%0d", i), fr, pick(), pick(), 0, e);
    end
    prev = e;

    // NCARE start: nothing happens
    start = 1'b1; funct = MULDIV_NCARE; a = 32'd3; b = 32'd4;
    nd = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done3 || done1 || busy3 || busy1) nd++;
    end
    chk("ncare_quiet", 64'(nd), 64'd0);
    chk("ncare_hold", {hi3, lo3}, prev);

    // flush in cycle 10 of a divide, then start+flush together
    start = 1'b1; funct = MULDIV_DIV; a = $urandom; b = $urandom;
    nd = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done3 || done1) nd++;
      start = 1'b0;
      if (c == 10) begin
        chk("flush_pre_busy", 64'({busy3, busy1}), 64'd3);
        flush = 1'b1;
      end
      if (c == 11) begin
        flush = 1'b0;
        chk("flush_busy", 64'({busy3, busy1}), 64'd0);
      end
      if (c == 13) begin
        start = 1'b1; flush = 1'b1; funct = MULDIV_DIVU; a = 32'd50; b = 32'd5;
      end
      if (c == 14) begin
        flush = 1'b0;
        chk("flush_start_busy", 64'({busy3, busy1}), 64'd0);
      end
    end
    chk("flush_nodone", 64'(nd), 64'd0);
    chk("flush_hold3", {hi3, lo3}, prev);
    chk("flush_hold1", {hi1, lo1}, prev);

    // reset in cycle 20 of a divide
    start = 1'b1; funct = MULDIV_DIV; a = 32'd1000; b = 32'd3;
    nd = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done3 || done1) nd++;
      start = 1'b0;
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin
        chk("rst_mid3", {busy3, done3, hi3, lo3}, 66'd0);
        chk("rst_mid1", {busy1, done1, hi1, lo1}, 66'd0);
        rst_n = 1'b1;
      end
    end
    chk("rst_nodone", 64'(nd), 64'd0);

    // back-to-back: DIVU issued in the MULTU done cycle of the latency-3 unit
    start = 1'b1; funct = MULDIV_MULTU; a = 32'd2; b = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done3) begin dq3.push_back(c); vq3.push_back({hi3, lo3}); end
      if (done1) begin dq1.push_back(c); vq1.push_back({hi1, lo1}); end
      start = 1'b0;
      if (c == 3) begin start = 1'b1; funct = MULDIV_DIVU; a = 32'd7; b = 32'd2; end
    end
    chk("b2b_n3", 64'(dq3.size()), 64'd2);
    chk("b2b_n1", 64'(dq1.size()), 64'd2);
    if (dq3.size() == 2) begin
      chk("b2b_cyc3a", 64'(dq3[0]), 64'd3);
      chk("b2b_val3a", vq3[0], model(MULDIV_MULTU, 32'd2, 32'd3));
      chk("b2b_cyc3b", 64'(dq3[1]), 64'd37);
      chk("b2b_val3b", vq3[1], model(MULDIV_DIVU, 32'd7, 32'd2));
    end
    if (dq1.size() == 2) begin
      chk("b2b_cyc1a", 64'(dq1[0]), 64'd1);
      chk("b2b_val1a", vq1[0], 64'd6);
      chk("b2b_cyc1b", 64'(dq1[1]), 64'd37);
      chk("b2b_val1b", vq1[1], {32'd1, 32'd3});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
